// File: rtl/dma_pkg.sv
// ============================================================================
// Module : dma_pkg
// Shared AXI constants, FSM state encoding and helpers for the DMA write master.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // log2 of the beat size in bytes, i.e. the AXI AxSIZE encoding
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] sz;
    sz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_wbuf.sv
// ============================================================================
// Module : dma_wbuf
// 2-entry skid buffer between the FIFO read port and the AXI W channel.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dma_wbuf
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_ren,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_level
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_inflight;
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;

  // Clearing also drops a read still in flight, so words fetched before an
  // abort never leak into the next transfer.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_inflight <= 1'b0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= 2'd0;
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      r_inflight <= i_ren;
      if (r_inflight) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, i_pop};
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign o_level = r_cnt + {1'b0, r_inflight};

endmodule

`default_nettype wire

// File: rtl/dma_axi_write_master.sv
// ============================================================================
// Module : dma_axi_write_master
// Drains the DMA FIFO into memory as 4 KB-safe AXI4 INCR write bursts.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dma_axi_write_master
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [LEN_WIDTH-1:0]    xfer_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic                    fifo_empty,
  output logic                    ren,
  input  logic [DATA_WIDTH-1:0]   data_out,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam logic [2:0] C_SIZE = axi_size(DATA_WIDTH / 8);
  localparam int         C_CW   = ((LEN_WIDTH > 13) ? LEN_WIDTH : 13) + 1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [LEN_WIDTH-1:0]  r_fetch;
  logic [8:0]            r_beats;
  logic [7:0]            r_awlen;
  logic [7:0]            r_beat;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [LEN_WIDTH-1:0]  w_next_rem;
  logic [12:0]           w_4k_beats;
  logic [12:0]           w_cap;
  logic [8:0]            w_beats;
  logic [7:0]            w_awlen_next;
  logic                  w_err;
  logic                  w_active;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_buf_valid;
  logic [1:0]            w_level;

  // Address/length of the burst about to be issued: the programmed values
  // from IDLE, otherwise the current burst advanced by its beat count.
  always_comb begin
    w_next_addr = r_addr + (ADDR_WIDTH'(r_beats) << C_SIZE);
    w_next_rem  = r_rem - LEN_WIDTH'(r_beats);
    if (r_state == S_IDLE) begin
      w_next_addr = dst_addr;
      w_next_rem  = xfer_len;
    end
  end

  assign w_4k_beats   = (13'h1000 - {1'b0, w_next_addr[11:0]}) >> C_SIZE;
  assign w_cap        = (w_4k_beats < 13'(MAX_BURST)) ? w_4k_beats : 13'(MAX_BURST);
  assign w_beats      = (C_CW'(w_next_rem) < C_CW'(w_cap)) ? 9'(w_next_rem) : 9'(w_cap);
  assign w_awlen_next = 8'(w_beats - 9'd1);
  assign w_err        = r_err | (bresp != AXI_RESP_OKAY);

  assign w_active = (r_state == S_AW) || (r_state == S_W) || (r_state == S_B);
  assign w_pop    = wvalid & wready;
  assign w_room   = (({1'b0, w_level} - {2'b0, w_pop}) < 3'd2);
  assign ren      = w_active & ~fifo_empty & (r_fetch != '0) & w_room;

  dma_wbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   ((r_state == S_IDLE) || (r_state == S_FIN)),
    .i_ren   (ren),
    .i_data  (data_out),
    .i_pop   (w_pop),
    .o_valid (w_buf_valid),
    .o_data  (wdata),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_fetch <= '0;
      r_beats <= '0;
      r_awlen <= '0;
      r_beat  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ren) r_fetch <= r_fetch - LEN_WIDTH'(1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err <= 1'b0;
            if (xfer_len != '0) begin
              r_state <= S_AW;
              r_busy  <= 1'b1;
              r_addr  <= w_next_addr;
              r_rem   <= w_next_rem;
              r_fetch <= xfer_len;
              r_beats <= w_beats;
              r_awlen <= w_awlen_next;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        S_AW: begin
          if (awready) begin
            r_state <= S_W;
            r_beat  <= '0;
          end
        end
        S_W: begin
          if (w_pop) begin
            if (wlast) r_state <= S_B;
            else       r_beat  <= r_beat + 8'd1;
          end
        end
        S_B: begin
          if (bvalid) begin
            r_err  <= w_err;
            r_addr <= w_next_addr;
            r_rem  <= w_next_rem;
            // A failed response abandons the bursts that remain
            if ((w_next_rem == '0) || w_err) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_AW;
              r_beats <= w_beats;
              r_awlen <= w_awlen_next;
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_done & r_err;
  assign awaddr  = r_addr;
  assign awlen   = r_awlen;
  assign awsize  = C_SIZE;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (r_state == S_AW);
  assign wvalid  = (r_state == S_W) & w_buf_valid;
  assign wlast   = wvalid & (r_beat == r_awlen);
  assign wstrb   = '1;
  assign bready  = (r_state == S_B);

endmodule

`default_nettype wire

// File: tb/tb_dma_axi_write_master.sv
// ============================================================================
// Module : tb_dma_axi_write_master
// Scoreboard bench: FIFO/AXI slave models with expected AW and W queues.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dma_axi_write_master;

  localparam int MB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dst_addr = '0;
  logic [15:0] xfer_len = '0;
  logic        busy, done, error;
  logic        fifo_empty = 1'b1;
  logic        ren;
  logic [31:0] data_out = '0;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b1;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid;
  logic        wready = 1'b1;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;

  dma_axi_write_master #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .LEN_WIDTH (16), .MAX_BURST (MB)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .dst_addr (dst_addr), .xfer_len (xfer_len),
    .busy (busy), .done (done), .error (error), .fifo_empty (fifo_empty), .ren (ren),
    .data_out (data_out), .awaddr (awaddr), .awlen (awlen), .awsize (awsize),
    .awburst (awburst), .awvalid (awvalid), .awready (awready), .wdata (wdata),
    .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
    .bresp (bresp), .bvalid (bvalid), .bready (bready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] fifo_q [$];
  logic [39:0] exp_aw [$];
  logic [31:0] exp_w  [$];
  logic [1:0]  resp_q [$];

  bit          rand_ready = 0;
  bit          toggle_empty = 0;
  bit          force_empty = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          first_w_cyc = 0, last_w_cyc = 0, b_cyc = 0;
  bit          w_allowed = 0;
  int          beat = 0;
  logic [7:0]  cur_awlen = '0;
  int          b_pending = 0;
  bit          b_hs = 0;
  logic [31:0] rd_data = '0;
  bit          rd_pend = 0;
  logic        p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0, p_wlast = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;
  logic [7:0]  p_awlen = '0;

  // FIFO read port model: one cycle of read latency
  always @(posedge clk) if (rd_pend) data_out <= rd_data;

  // Slave/FIFO models and scoreboard; inputs settle before the next rising edge
  always @(negedge clk) begin
    logic [39:0] ea;
    logic [31:0] ew;
    logic        el;
    rd_pend = 0;
    if (b_hs) begin bvalid = 0; b_hs = 0; end
    if (rst) begin
      bvalid = 0; b_pending = 0; w_allowed = 0; beat = 0;
      awready = 1; wready = 1; fifo_empty = 1;
      p_awvalid = 0; p_wvalid = 0;
    end else begin
      awready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      force_empty = toggle_empty ? !force_empty : 1'b0;
      fifo_empty = force_empty || (fifo_q.size() == 0);
      if (b_pending > 0 && !bvalid) begin
        bvalid = 1;
        bresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
      end
      #1;
      if (p_awvalid && !p_awready) begin
        checks++;
        if (!awvalid || awaddr !== p_awaddr || awlen !== p_awlen) begin
          errors++;
          $display("FAIL aw_stable: got v=%b addr=%h len=%0d, need addr=%h len=%0d", awvalid, awaddr, awlen, p_awaddr, p_awlen);
        end
      end
      if (p_wvalid && !p_wready) begin
        checks++;
        if (!wvalid || wdata !== p_wdata || wlast !== p_wlast) begin
          errors++;
          $display("FAIL w_stable: got v=%b data=%h last=%b, need data=%h last=%b", wvalid, wdata, wlast, p_wdata, p_wlast);
        end
      end
      if (wvalid) begin
        checks++;
        if (!w_allowed) begin
          errors++;
          $display("FAIL w_before_aw: got wvalid=1 with no open AW, need 0");
        end
      end
      if (awvalid && awready) begin
        checks++;
        if (exp_aw.size() == 0) begin
          errors++;
          $display("FAIL aw_unexpected: got addr=%h len=%0d, need no AW", awaddr, awlen);
        end else begin
          ea = exp_aw.pop_front();
          if ({awaddr, awlen} !== ea || awsize !== 3'd2 || awburst !== 2'b01) begin
            errors++;
            $display("FAIL aw: got addr=%h len=%0d size=%0d burst=%0d, need addr=%h len=%0d size=2 burst=1",
                     awaddr, awlen, awsize, awburst, ea[39:8], ea[7:0]);
          end
        end
        cur_awlen = awlen; beat = 0; w_allowed = 1; aw_cnt++;
      end
      if (wvalid && wready) begin
        checks++;
        el = (beat == int'(cur_awlen));
        if (exp_w.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected: got data=%h, need no beat", wdata);
        end else begin
          ew = exp_w.pop_front();
          if (wdata !== ew || wlast !== el || wstrb !== 4'hF) begin
            errors++;
            $display("FAIL w: got data=%h last=%b strb=%h, need data=%h last=%b strb=f", wdata, wlast, wstrb, ew, el);
          end
        end
        beat++;
        if (w_cnt == 0) first_w_cyc = cyc;
        last_w_cyc = cyc;
        w_cnt++;
        if (el) begin w_allowed = 0; b_pending++; end
      end
      if (bvalid && bready) begin
        b_hs = 1; b_pending--; b_cnt++; b_cyc = cyc;
      end
      if (ren) begin
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL ren_empty: got ren=1 with fifo_empty=1, need ren=0");
        end else begin
          rd_data = fifo_q.pop_front();
          rd_pend = 1;
        end
      end
      p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr; p_awlen = awlen;
      p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wlast = wlast;
    end
  end

  task automatic clear_state();
    fifo_q.delete(); exp_aw.delete(); exp_w.delete(); resp_q.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
  endtask

  task automatic load_fifo(input int n, input int n_exp);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      if (i < n_exp) exp_w.push_back(w);
    end
  endtask

  task automatic model_bursts(input logic [31:0] dst, input int len, input int max_b);
    int unsigned a;
    int rem, b, room, nb;
    a = dst; rem = len; nb = 0;
    while (rem > 0 && nb < max_b) begin
      room = (4096 - int'(a % 4096)) / 4;
      b = (rem < MB) ? rem : MB;
      if (room < b) b = room;
      exp_aw.push_back({a, 8'(b - 1)});
      a += 32'(b * 4); rem -= b; nb++;
    end
  endtask

  task automatic kick(input logic [31:0] dst, input int len);
    @(posedge clk); #2;
    dst_addr = dst; xfer_len = 16'(len); start = 1;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic wait_done(output bit seen, output bit err, output int dcyc);
    seen = 0; err = 0; dcyc = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk); #3;
      if (done) begin seen = 1; err = error; dcyc = cyc; end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, ren, awvalid, wvalid, wlast, bready} !== 8'h00) begin
      errors++;
      $display("FAIL reset: got busy/done/err/ren/awv/wv/wl/br=%b, need 00000000",
               {busy, done, error, ren, awvalid, wvalid, wlast, bready});
    end
    @(posedge clk); #2;
    rst = 0;
  endtask

  task automatic test_single_burst();
    bit seen, err; int dc;
    clear_state(); rand_ready = 0; toggle_empty = 0;
    load_fifo(8, 8); model_bursts(32'h1000, 8, 99);
    kick(32'h1000, 8);
    @(negedge clk); #3;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b, need 1", busy); end
    wait_done(seen, err, dc);
    checks++;
    if (!seen || err) begin errors++; $display("FAIL t1_done: got seen=%b err=%b, need 1 0", seen, err); end
    checks++;
    if (aw_cnt != 1 || exp_aw.size() != 0 || exp_w.size() != 0) begin
      errors++; $display("FAIL t1_counts: got aw=%0d left_aw=%0d left_w=%0d, need 1 0 0", aw_cnt, exp_aw.size(), exp_w.size());
    end
    checks++;
    if (last_w_cyc - first_w_cyc != 7) begin
      errors++; $display("FAIL t1_bubbles: got span=%0d, need 7", last_w_cyc - first_w_cyc);
    end
    checks++;
    if (dc - b_cyc != 1) begin errors++; $display("FAIL t1_done_lat: got %0d, need 1", dc - b_cyc); end
    @(negedge clk); #3;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t1_after: got done=%b busy=%b, need 0 0", done, busy);
    end
  endtask

  task automatic test_burst_run(input string nm, input logic [31:0] dst, input int len, input int n_aw);
    bit seen, err; int dc;
    clear_state();
    load_fifo(len, len); model_bursts(dst, len, 99);
    kick(dst, len);
    wait_done(seen, err, dc);
    checks++;
    if (!seen || err) begin errors++; $display("FAIL %s_done: got seen=%b err=%b, need 1 0", nm, seen, err); end
    checks++;
    if (aw_cnt != n_aw || exp_aw.size() != 0 || exp_w.size() != 0) begin
      errors++; $display("FAIL %s_counts: got aw=%0d left_aw=%0d left_w=%0d, need %0d 0 0",
                         nm, aw_cnt, exp_aw.size(), exp_w.size(), n_aw);
    end
  endtask

  task automatic test_4k_split();
    rand_ready = 0; toggle_empty = 0;
    test_burst_run("t2", 32'h0000_0FF8, 4, 2);
  endtask

  task automatic test_multi_burst();
    rand_ready = 0; toggle_empty = 0;
    test_burst_run("t3", 32'h0000_2000, 40, 3);
  endtask

  task automatic test_stall();
    rand_ready = 1; toggle_empty = 1;
    test_burst_run("t4", 32'h0000_3FF0, 20, 2);
    rand_ready = 0; toggle_empty = 0;
  endtask

  task automatic test_error();
    bit seen, err; int dc, aw0;
    clear_state(); rand_ready = 0; toggle_empty = 0;
    resp_q.push_back(2'b00); resp_q.push_back(2'b10);
    load_fifo(48, 32); model_bursts(32'h4000, 48, 2);
    kick(32'h4000, 48);
    wait_done(seen, err, dc);
    checks++;
    if (!seen || !err) begin errors++; $display("FAIL t5_done: got seen=%b err=%b, need 1 1", seen, err); end
    repeat (4) @(negedge clk);
    checks++;
    if (aw_cnt != 2 || exp_aw.size() != 0 || exp_w.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_abort: got aw=%0d left_w=%0d busy=%b, need 2 0 0", aw_cnt, exp_w.size(), busy);
    end
    fifo_q.delete();
    aw0 = aw_cnt;
    kick(32'h5000, 0);
    @(negedge clk); #3;
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t5_zero: got done=%b err=%b busy=%b, need 1 0 0", done, error, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (aw_cnt != aw0 || done !== 1'b0) begin
      errors++; $display("FAIL t5_zero_quiet: got aw=%0d done=%b, need %0d 0", aw_cnt, done, aw0);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, err, hit; int dc;
    clear_state(); rand_ready = 0; toggle_empty = 0;
    load_fifo(16, 16); model_bursts(32'h6000, 16, 99);
    kick(32'h6000, 16);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #3;
      if (w_cnt >= 3) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL t6_reach: got beats=%0d, need 3", w_cnt); end
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, error, ren, awvalid, wvalid, wlast, bready} !== 8'h00) begin
      errors++;
      $display("FAIL t6_reset: got busy/done/err/ren/awv/wv/wl/br=%b, need 00000000",
               {busy, done, error, ren, awvalid, wvalid, wlast, bready});
    end
    @(posedge clk); #2;
    clear_state();
    rst = 0;
    test_burst_run("t6_after", 32'h7000, 8, 1);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout, need completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    test_reset();
    test_single_burst();
    test_4k_split();
    test_multi_burst();
    test_stall();
    test_error();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
